// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder block: beat counter width and
// the encoding of the serial_en mode input.
package full_adder_pkg;

    localparam int BEAT_CNT_W = 8;

    localparam logic MODE_PARALLEL = 1'b0;
    localparam logic MODE_SERIAL   = 1'b1;

    localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_ZERO = {BEAT_CNT_W{1'b0}};
    localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_ONE  = {{(BEAT_CNT_W-1){1'b0}}, 1'b1};

endpackage : full_adder_pkg

// File: rtl/full_adder_fa_cell.sv
// Purely combinational one-bit full adder cell.
// It holds no state; the registers and the carry-in mux are in full_adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : fa_cell

// File: rtl/full_adder.sv
// Registered one-bit full adder with an optional bit-serial mode that chains
// the carry across beats of a word delivered LSB first.
module full_adder
    import full_adder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  serial_en,
    input  logic                  first,
    input  logic                  x,
    input  logic                  y,
    input  logic                  z,
    output logic                  sumf,
    output logic                  carryf,
    output logic                  out_valid,
    output logic [BEAT_CNT_W-1:0] beat_cnt
);

    logic                  w_cin;
    logic                  w_sum;
    logic                  w_cout;

    logic                  r_sumf;
    logic                  r_carryf;
    logic                  r_carry_q;
    logic                  r_out_valid;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;

    // Carry-in select: the stored carry is used only inside a serial word.
    always_comb begin
        w_cin = z;
        if ((serial_en == MODE_SERIAL) && (first == 1'b0)) begin
            w_cin = r_carry_q;
        end else begin
            w_cin = z;
        end
    end

    fa_cell u_fa_cell (
        .a    (x),
        .b    (y),
        .cin  (w_cin),
        .s    (w_sum),
        .cout (w_cout)
    );

    // Result, carry chain and beat counter registers; all hold when no beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sumf      <= 1'b0;
            r_carryf    <= 1'b0;
            r_carry_q   <= 1'b0;
            r_out_valid <= 1'b0;
            r_beat_cnt  <= BEAT_CNT_ZERO;
        end else if (in_valid) begin
            r_sumf      <= w_sum;
            r_carryf    <= w_cout;
            r_carry_q   <= w_cout;
            r_out_valid <= 1'b1;
            r_beat_cnt  <= r_beat_cnt + BEAT_CNT_ONE;
        end else begin
            r_sumf      <= r_sumf;
            r_carryf    <= r_carryf;
            r_carry_q   <= r_carry_q;
            r_out_valid <= 1'b0;
            r_beat_cnt  <= r_beat_cnt;
        end
    end

    assign sumf      = r_sumf;
    assign carryf    = r_carryf;
    assign out_valid = r_out_valid;
    assign beat_cnt  = r_beat_cnt;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: directed cases plus randomized beats
// compared against an arithmetic reference model.
module tb_full_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       serial_en;
    logic       first;
    logic       x;
    logic       y;
    logic       z;
    logic       sumf;
    logic       carryf;
    logic       out_valid;
    logic [7:0] beat_cnt;

    int n_cmp;
    int n_mis;

    // reference model state
    int m_sum;
    int m_carry;
    int m_cq;
    int m_valid;
    int m_cnt;

    full_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .serial_en (serial_en),
        .first     (first),
        .x         (x),
        .y         (y),
        .z         (z),
        .sumf      (sumf),
        .carryf    (carryf),
        .out_valid (out_valid),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_cmp = n_cmp + 1;
        if (obs != exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk_eq({tag, ".sumf"},      int'(sumf),      m_sum);
        chk_eq({tag, ".carryf"},    int'(carryf),    m_carry);
        chk_eq({tag, ".out_valid"}, int'(out_valid), m_valid);
        chk_eq({tag, ".beat_cnt"},  int'(beat_cnt),  m_cnt);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check 1 ns later.
    task automatic step(input logic iv, input logic se, input logic f,
                        input logic xx, input logic yy, input logic zz, input string tag);
        int cin_m;
        int tot;
        in_valid  = iv;
        serial_en = se;
        first     = f;
        x         = xx;
        y         = yy;
        z         = zz;
        @(posedge clk);
        if (iv) begin
            cin_m   = (se && !f) ? m_cq : int'(zz);
            tot     = int'(xx) + int'(yy) + cin_m;
            m_sum   = tot % 2;
            m_carry = tot / 2;
            m_cq    = tot / 2;
            m_valid = 1;
            m_cnt   = (m_cnt + 1) % 256;
        end else begin
            m_valid = 0;
        end
        #1;
        chk_model(tag);
    endtask

    // Assert reset between edges, check the asynchronous clear, release before the next edge.
    task automatic do_reset(input string tag);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_sum = 0; m_carry = 0; m_cq = 0; m_valid = 0; m_cnt = 0;
        chk_model(tag);
        #2;
        rst_n = 1'b1;
    endtask

    // Feed a 4-bit serial word and compare the collected result with plain addition.
    task automatic serial_word(input logic [3:0] a, input logic [3:0] b, input logic cin0,
                               input string tag);
        logic [3:0] a_v;
        logic [3:0] b_v;
        int         res;
        a_v = a;
        b_v = b;
        res = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, (i == 0), a_v[i], b_v[i], (i == 0) ? cin0 : 1'b0, tag);
            res = res | (int'(sumf) << i);
        end
        res = res | (int'(carryf) << 4);
        chk_eq({tag, ".word"}, res, int'(a) + int'(b) + int'(cin0));
    endtask

    initial begin
        logic [2:0] tv;
        int         exp_s [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
        int         exp_c [8] = '{0, 0, 0, 1, 0, 1, 1, 1};
        int         held_cnt;
        n_cmp = 0;
        n_mis = 0;
        m_sum = 0; m_carry = 0; m_cq = 0; m_valid = 0; m_cnt = 0;
        rst_n = 1'b0; in_valid = 1'b0; serial_en = 1'b0; first = 1'b0;
        x = 1'b0; y = 1'b0; z = 1'b0;
        #1;
        chk_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // parallel truth table, x varies fastest
        for (int i = 0; i < 8; i++) begin
            tv = 3'(i);
            step(1'b1, 1'b0, tv[1], tv[0], tv[1], tv[2], "ttab");
            chk_eq("ttab.sum_const",   int'(sumf),      exp_s[i]);
            chk_eq("ttab.carry_const", int'(carryf),    exp_c[i]);
            chk_eq("ttab.valid_const", int'(out_valid), 1);
        end

        serial_word(4'b1011, 4'b0110, 1'b0, "ser_add");
        chk_eq("ser_add.carry", int'(carryf), 1);
        serial_word(4'b1111, 4'b0000, 1'b1, "ser_cin");
        chk_eq("ser_cin.sum3", int'(sumf), 0);

        // hold behaviour after beat (1,1,0)
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "hold_beat");
        held_cnt = int'(beat_cnt);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "hold");
            chk_eq("hold.valid", int'(out_valid), 0);
            chk_eq("hold.sumf",  int'(sumf),      0);
            chk_eq("hold.carry", int'(carryf),    1);
            chk_eq("hold.cnt",   int'(beat_cnt),  m_cnt);
        end
        chk_eq("hold.cnt_same", m_cnt, held_cnt);

        // reset mid serial word discards the stored carry
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "mid_beat");
        do_reset("mid_rst");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "post_rst");
        chk_eq("post_rst.sumf",  int'(sumf),   1);
        chk_eq("post_rst.carry", int'(carryf), 0);

        // randomized mixed-mode traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 4) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom), "rand");
        end

        // counter wrap from a fresh reset
        do_reset("wrap_rst");
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), "wrap");
        end
        chk_eq("wrap.256", int'(beat_cnt), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "wrap");
        chk_eq("wrap.257", int'(beat_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_full_adder

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 One clock, clk; reset is asynchronous and active-low, rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  qualifies x/y/z/first on the current rising edge.
REQ-005 serial_en  input  1  0 = independent single-bit add; 1 = bit-serial multi-bit add, LSB first.
REQ-006 first  input  1  serial mode only: marks LSB beat of a new operand word.
REQ-007 x  input  1  addend bit A.
REQ-008 y  input  1  addend bit B.
REQ-009 z  input  1  carry-in bit.
REQ-010 sumf  output  1  registered sum bit.
REQ-011 carryf  output  1  registered carry-out bit.
REQ-012 out_valid  output  1  high for one cycle per accepted beat.
REQ-013 beat_cnt  output  8  count of accepted beats since reset, wraps 255->0.

Function
REQ-014 Combinational core SHALL compute s = x^y^cin and c = (x&y)|(x&cin)|(y&cin).
REQ-015 Parallel mode (serial_en=0): cin SHALL be z; first SHALL be ignored.
REQ-016 Serial mode (serial_en=1): cin SHALL be z when first=1, otherwise the internal carry register carry_q.
REQ-017 On each edge with in_valid=1: sumf<=s, carryf<=c, carry_q<=c, out_valid<=1, beat_cnt<=beat_cnt+1 (mod 256).
REQ-018 On each edge with in_valid=0: out_valid<=0; sumf, carryf, carry_q and beat_cnt SHALL hold.
REQ-019 Latency SHALL be exactly one clock from accepted inputs to sumf/carryf/out_valid; full throughput, one beat per cycle, no backpressure.
REQ-020 Switching serial_en between beats SHALL take effect on the next accepted beat; carry_q is still updated in parallel mode but unused there.
REQ-021 Serial mode with first=0 immediately after reset SHALL use carry_q=0 as cin.
REQ-022 Inputs are sampled only on rising clk edges; no combinational path from any input to any output.

Reset
REQ-023 While rst_n=0: sumf=0, carryf=0, out_valid=0, carry_q=0, beat_cnt=0, applied asynchronously.
REQ-024 Reset deassertion SHALL be consumed synchronously; first accepted beat is on the first rising edge with rst_n=1 and in_valid=1.
REQ-025 Reset asserted mid serial word SHALL discard the partial carry; the next word must restart with first=1 or begins with cin=0.

Structure
REQ-026 Package full_adder_pkg SHALL hold BEAT_CNT_W=8 and the mode encoding constants MODE_PARALLEL=0, MODE_SERIAL=1.
REQ-027 One combinational sub-module fa_cell (ports a, b, cin, s, cout) SHALL implement REQ-014; full_adder holds cin mux, registers and counter.

Verification
REQ-028 Parallel truth table: serial_en=0, in_valid=1, (x,y,z) stepped 000,100,010,110,001,101,011,111 -> one cycle later (sumf,carryf)=00,10,10,01,10,01,01,11, out_valid=1 each cycle.
REQ-029 Serial add: serial_en=1, 4 beats LSB first of A=0b1011, B=0b0110, first=1,z=0 on beat 0 -> sumf stream 1,0,0,0, final carryf=1 (result 10001).
REQ-030 Serial carry-in: A=0b1111, B=0b0000, first=1 with z=1 -> sumf 0,0,0,0, final carryf=1.
REQ-031 Hold: in_valid low 3 cycles after beat (1,1,0) -> out_valid=0, sumf=0, carryf=1 held, beat_cnt unchanged.
REQ-032 Async reset mid serial word after beat (1,1,0): rst_n low between edges -> outputs 0 immediately; next serial beat first=0, x=1,y=0 -> sumf=1, carryf=0.
REQ-033 Counter wrap: 256 accepted beats from reset -> beat_cnt=0, 257th -> 1.
